ddr_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the `ddr_model` memory. It shares the single memory port between the CPU data port (port 0) and a secondary master such as DMA or instruction fetch (port 1). For each granted request it issues exactly one single-cycle `rd_req`/`wr_req` strobe and waits for `rd_valid` on reads. Each transaction completes with an `ack` pulse, or with an error if a read times out.

---
 rtl/ddr_arbiter_pkg.sv | 6 +
 rtl/ddr_arbiter_if.sv | 26 ++
 rtl/ddr_arbiter_rr_arbiter2.sv | 13 +
 rtl/ddr_arbiter.sv | 75 +++++++
 tb/tb_ddr_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_arbiter_pkg.sv
// ddr_arb_pkg: shared types and constants for the two-port DDR arbiter
package ddr_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef logic port_t;
  localparam int DEFAULT_RD_TIMEOUT = 64;
endpackage

// File: rtl/ddr_arbiter_if.sv
// ddr_arbiter_if: requester ports and memory port of the DDR arbiter
interface ddr_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic                  m0_req, m1_req, m0_we, m1_we;
  logic [ADDR_WIDTH-1:0] m0_addr, m1_addr;
  logic [DATA_WIDTH-1:0] m0_wdata, m1_wdata;
  logic                  m0_ack, m1_ack, m0_err, m1_err;
  logic [DATA_WIDTH-1:0] m0_rdata, m1_rdata;
  logic                  ddr_rd_req, ddr_wr_req, ddr_rd_valid;
  logic [ADDR_WIDTH-1:0] ddr_addr;
  logic [DATA_WIDTH-1:0] ddr_wr_data, ddr_rd_data;
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  ddr_rd_data, ddr_rd_valid,
    output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    output ddr_rd_req, ddr_wr_req, ddr_addr, ddr_wr_data
  );
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output ddr_rd_data, ddr_rd_valid,
    input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
    input  ddr_rd_req, ddr_wr_req, ddr_addr, ddr_wr_data
  );
endinterface

// File: rtl/ddr_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin pick; on a tie the port that was not granted last wins
module rr_arbiter2
  import ddr_arb_pkg::*;
(
  input  logic  i_req0,
  input  logic  i_req1,
  input  port_t i_last,
  output port_t o_gnt,
  output logic  o_valid
);
  assign o_valid = i_req0 | i_req1;
  assign o_gnt   = (i_req0 & i_req1) ? ~i_last : i_req1;
endmodule

// File: rtl/ddr_arbiter.sv
// ddr_arbiter: shares one ddr_model port between two masters, one strobe per grant,
// read completion on rd_valid or timeout error, one-cycle ack to the granted port
module ddr_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RD_TIMEOUT = DEFAULT_RD_TIMEOUT
) (
  input logic clk,
  input logic reset,
  ddr_arbiter_if.slave bus
);
  localparam int CW = $clog2(RD_TIMEOUT);
  state_t                r_state, w_next;
  port_t                 r_last, w_gnt;
  logic                  w_valid, w_tmo, w_ack, r_we, r_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [CW-1:0]         r_cnt;
  rr_arbiter2 u_rr (
    .i_req0 (bus.m0_req),
    .i_req1 (bus.m1_req),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_valid(w_valid)
  );
  assign w_tmo = r_cnt == CW'(RD_TIMEOUT - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_valid ? ISSUE : IDLE;
      ISSUE:   w_next = r_we ? RESP : WAIT;
      WAIT:    w_next = (bus.ddr_rd_valid || w_tmo) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // r_last doubles as the index of the port currently being served
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE && w_valid) begin
      r_last  <= w_gnt;
      r_we    <= w_gnt ? bus.m1_we : bus.m0_we;
      r_addr  <= w_gnt ? bus.m1_addr : bus.m0_addr;
      r_wdata <= w_gnt ? bus.m1_wdata : bus.m0_wdata;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == WAIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (bus.ddr_rd_valid) r_rdata <= bus.ddr_rd_data;
      else if (w_tmo)       r_err   <= 1'b1;
    end
  assign w_ack           = r_state == RESP;
  assign bus.ddr_wr_req  = r_state == ISSUE && r_we;
  assign bus.ddr_rd_req  = r_state == ISSUE && !r_we;
  assign bus.ddr_addr    = r_addr;
  assign bus.ddr_wr_data = r_wdata;
  assign bus.m0_ack      = w_ack && !r_last;
  assign bus.m1_ack      = w_ack && r_last;
  assign bus.m0_rdata    = (w_ack && !r_last) ? r_rdata : '0;
  assign bus.m1_rdata    = (w_ack && r_last) ? r_rdata : '0;
  assign bus.m0_err      = w_ack && !r_last && r_err;
  assign bus.m1_err      = w_ack && r_last && r_err;
endmodule

// File: tb/tb_ddr_arbiter.sv
// tb_ddr_arbiter: transaction-level model of two requesters and a memory, checked every cycle against the arbiter
module tb_ddr_arbiter;
  import ddr_arb_pkg::*;
  localparam int DW = 32, AW = 10, TMO = 8;
  typedef struct {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} txn_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  ddr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  ddr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_TIMEOUT(TMO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  int errors = 0, checks = 0;
  txn_t q0[$], q1[$];
  logic [DW-1:0] mem[1024];
  logic [DW-1:0] exp_rd, last_rdata;
  int cyc = 0, ack_cyc = 0, valid_cyc = -1;
  bit busy = 0, is_rd = 0, exp_p = 0, exp_err = 0, last_p = 1;
  bit stray_en = 0, no_valid = 0, req_prev0 = 0, req_prev1 = 0;
  int grants[$];

  task automatic step();
    txn_t t;
    bit p, a0, a1, drop0, drop1;
    @(negedge clk);
    cyc++;
    drop0 = 0;
    drop1 = 0;
    if (bus.ddr_rd_req || bus.ddr_wr_req) begin
      checks++;
      if (busy || (bus.ddr_rd_req && bus.ddr_wr_req) || !(req_prev0 || req_prev1)) begin
        errors++;
        $display("FAIL strobe: unexpected strobe rd=%b wr=%b while busy=%b req0=%b req1=%b",
                 bus.ddr_rd_req, bus.ddr_wr_req, busy, req_prev0, req_prev1);
      end else begin
        p = (req_prev0 && req_prev1) ? !last_p : req_prev1;
        t = p ? q1[0] : q0[0];
        checks++;
        if (bus.ddr_wr_req !== t.we || bus.ddr_addr !== t.addr || (t.we && bus.ddr_wr_data !== t.wdata)) begin
          errors++;
          $display("FAIL issue: got wr=%b addr=%h data=%h, required port %0d wr=%b addr=%h data=%h",
                   bus.ddr_wr_req, bus.ddr_addr, bus.ddr_wr_data, p, t.we, t.addr, t.wdata);
        end
        busy = 1; exp_p = p; last_p = p; is_rd = !t.we; exp_err = 0; exp_rd = '0;
        grants.push_back(int'(p));
        if (t.we) begin
          mem[t.addr] = t.wdata;
          ack_cyc = cyc + 1; valid_cyc = -1;
        end else if (no_valid) begin
          ack_cyc = cyc + TMO + 1; valid_cyc = -1; exp_err = 1;
        end else begin
          valid_cyc = cyc + int'($urandom_range(1, 5));
          ack_cyc = valid_cyc + 1; exp_rd = mem[t.addr];
        end
      end
    end
    a0 = busy && cyc == ack_cyc && !exp_p;
    a1 = busy && cyc == ack_cyc && exp_p;
    checks++;
    if ({bus.m1_ack, bus.m0_ack} !== {a1, a0} || bus.m0_rdata !== (a0 ? exp_rd : '0) ||
        bus.m1_rdata !== (a1 ? exp_rd : '0) || bus.m0_err !== (a0 && exp_err) || bus.m1_err !== (a1 && exp_err)) begin
      errors++;
      $display("FAIL ack@%0d: got ack=%b%b rd0=%h rd1=%h err=%b%b, required ack=%b%b rd=%h err=%b",
               cyc, bus.m1_ack, bus.m0_ack, bus.m0_rdata, bus.m1_rdata, bus.m1_err, bus.m0_err,
               a1, a0, exp_rd, exp_err);
    end
    if (busy && cyc >= ack_cyc) begin
      busy = 0;
      last_rdata = exp_p ? bus.m1_rdata : bus.m0_rdata;
      if (exp_p) begin void'(q1.pop_front()); drop1 = 1; end
      else begin void'(q0.pop_front()); drop0 = 1; end
    end
    bus.m0_req = q0.size() > 0 && !drop0;
    bus.m1_req = q1.size() > 0 && !drop1;
    {bus.m0_we, bus.m0_addr, bus.m0_wdata} = bus.m0_req ? {q0[0].we, q0[0].addr, q0[0].wdata} : '0;
    {bus.m1_we, bus.m1_addr, bus.m1_wdata} = bus.m1_req ? {q1[0].we, q1[0].addr, q1[0].wdata} : '0;
    req_prev0 = bus.m0_req;
    req_prev1 = bus.m1_req;
    if (busy && is_rd) begin
      bus.ddr_rd_valid = cyc == valid_cyc;
      bus.ddr_rd_data = (cyc == valid_cyc) ? exp_rd : $urandom;
    end else begin
      bus.ddr_rd_valid = stray_en && $urandom_range(0, 1) == 1;
      bus.ddr_rd_data = $urandom;
    end
  endtask

  task automatic run(input int maxc);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && n < maxc) begin
      step();
      n++;
    end
    checks++;
    if (busy || q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL run_timeout: %0d/%0d transactions still pending after %0d cycles", q0.size(), q1.size(), maxc);
      q0.delete(); q1.delete(); busy = 0;
    end
    repeat (2) step();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.ddr_rd_req, bus.ddr_wr_req, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 6'b0 ||
        bus.ddr_addr !== '0 || bus.ddr_wr_data !== '0 || bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
      errors++;
      $display("FAIL reset_state: strobes=%b%b acks=%b%b addr=%h wdata=%h, required all 0",
               bus.ddr_rd_req, bus.ddr_wr_req, bus.m0_ack, bus.m1_ack, bus.ddr_addr, bus.ddr_wr_data);
    end
    reset = 1'b0;
  endtask

  task automatic test_write();
    q0.push_back('{1'b1, AW'(10), 32'hDEADBEEF});
    run(20);
  endtask

  task automatic test_read();
    q1.push_back('{1'b0, AW'(10), '0});
    run(30);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_back: got %h, required deadbeef", last_rdata);
    end
  endtask

  task automatic test_alternate();
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, AW'($urandom_range(16, 1023)), '0});
      q1.push_back('{1'b0, AW'($urandom_range(16, 1023)), '0});
    end
    run(200);
    checks++;
    if (grants.size() != 8) begin
      errors++;
      $display("FAIL alt_count: got %0d grants, required 8", grants.size());
    end
    for (int i = 0; i < grants.size() && i < 8; i++) begin
      checks++;
      if (grants[i] != i % 2) begin
        errors++;
        $display("FAIL alt_order[%0d]: got port %0d, required %0d", i, grants[i], i % 2);
      end
    end
  endtask

  task automatic test_timeout();
    no_valid = 1;
    q0.push_back('{1'b0, AW'($urandom_range(16, 1023)), '0});
    run(40);
    no_valid = 0;
    q1.push_back('{1'b1, AW'(20), $urandom});
    q0.push_back('{1'b0, AW'(20), '0});
    run(40);
  endtask

  task automatic test_stray();
    stray_en = 1;
    repeat (10) step();
    for (int i = 0; i < 6; i++) begin
      q0.push_back('{1'b1, AW'($urandom_range(16, 1023)), $urandom});
      q1.push_back('{1'b1, AW'($urandom_range(16, 1023)), $urandom});
    end
    run(200);
    stray_en = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      txn_t t;
      t = '{1'($urandom_range(0, 1)), AW'($urandom_range(16, 31)), $urandom};
      if ($urandom_range(0, 1) == 1) q1.push_back(t);
      else q0.push_back(t);
    end
    stray_en = 1;
    run(1000);
    stray_en = 0;
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    no_valid = 1;
    q0.push_back('{1'b0, AW'(40), '0});
    while (!busy && n < 20) begin step(); n++; end
    repeat (3) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.ddr_rd_req, bus.ddr_wr_req, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 6'b0 ||
        bus.ddr_addr !== '0 || bus.ddr_wr_data !== '0 || bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
      errors++;
      $display("FAIL reset_async: strobes=%b%b acks=%b%b addr=%h, required all 0",
               bus.ddr_rd_req, bus.ddr_wr_req, bus.m0_ack, bus.m1_ack, bus.ddr_addr);
    end
    q0.delete(); q1.delete();
    busy = 0; last_p = 1; no_valid = 0;
    bus.m0_req = 0; bus.m1_req = 0; req_prev0 = 0; req_prev1 = 0;
    repeat (2) step();
    reset = 1'b0;
    stray_en = 1;
    repeat (6) step();
    stray_en = 0;
    q1.push_back('{1'b0, AW'(10), '0});
    run(30);
    checks++;
    if (last_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_reset_read: got %h, required deadbeef", last_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    {bus.m0_req, bus.m1_req, bus.m0_we, bus.m1_we, bus.ddr_rd_valid} = '0;
    {bus.m0_addr, bus.m1_addr, bus.m0_wdata, bus.m1_wdata, bus.ddr_rd_data} = '0;
    test_reset();
    test_write();
    test_read();
    test_alternate();
    test_timeout();
    test_stray();
    test_random();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
